// File: rtl/display_scan_ctrl.sv
// Scan controller for a four-digit 7-segment display: steps a digit index at the
// refresh rate and presents each digit of a per-frame BCD snapshot with a blank flag.
`timescale 1ns/1ps

module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    output logic [1:0]  scan_cnt,
    output logic [3:0]  digit_bcd,
    output logic        digit_blank,
    output logic        frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [1:0]    scan_q, scan_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    digit_bcd_q, digit_bcd_d;
    logic          digit_blank_q, digit_blank_d;
    logic          frame_start_q, frame_start_d;

    logic          tick;
    logic          frame_wrap;
    logic [3:0]    next_nibble;

    // Blank for leading zeros: digit idx >= 1 whose own and all higher digits are zero.
    function automatic logic lz_blank(input logic [15:0] snap, input logic [1:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(idx) && snap[4*k +: 4] != 4'd0) begin
                all_zero = 1'b0;
            end
        end
        return (idx != 2'd0) && all_zero;
    endfunction

    assign tick       = (prescaler_q == PRESCALE_MAX);
    assign frame_wrap = tick && (scan_q == 2'd3);

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        prescaler_d   = prescaler_q + 1'b1;
        scan_d        = scan_q;
        snap_d        = snap_q;
        digit_bcd_d   = digit_bcd_q;
        digit_blank_d = digit_blank_q;
        frame_start_d = 1'b0;
        next_nibble   = 4'd0;

        if (tick) begin
            prescaler_d = '0;
            scan_d      = scan_q + 2'd1;
        end

        if (frame_wrap) begin
            snap_d        = bcd_in;
            frame_start_d = 1'b1;
        end

        // Outputs are computed from the values being loaded this edge, so digit 0
        // shows a freshly captured value in the same cycle it is captured.
        next_nibble = snap_d[{scan_d, 2'b00} +: 4];
        if (tick) begin
            digit_bcd_d   = next_nibble;
            digit_blank_d = (next_nibble > 4'd9) || (blank_lz && lz_blank(snap_d, scan_d));
        end
    end

    // NOTE: the snapshot is reset along with everything else so a mid-frame reset
    // can never expose stale digits; it is a plain register, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q   <= '0;
            scan_q        <= 2'd0;
            snap_q        <= 16'd0;
            digit_bcd_q   <= 4'd0;
            digit_blank_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            prescaler_q   <= prescaler_d;
            scan_q        <= scan_d;
            snap_q        <= snap_d;
            digit_bcd_q   <= digit_bcd_d;
            digit_blank_q <= digit_blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign scan_cnt    = scan_q;
    assign digit_bcd   = digit_bcd_q;
    assign digit_blank = digit_blank_q;
    assign frame_start = frame_start_q;

endmodule
